// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 64-bit ALU between two requesters, with a registered response
// and an optional Y86-64 condition-code register (built only when ALU_ARB_CC_EN is defined).
module alu_arbiter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_set_cc,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_overflow,
   output logic             cc_zf,
   output logic             cc_sf,
   output logic             cc_of
);

   // Returns {overflow, result}; overflow is signed two's-complement for add/sub only.
   function automatic logic [WIDTH:0] alu_f(input logic [1:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      logic             ovf;
      r   = {WIDTH{1'b0}};
      ovf = 1'b0;
      case (op)
         2'd0: begin
            r   = a + b;
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         2'd1: begin
            r   = a - b;
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         2'd2:    r = a & b;
         2'd3:    r = a ^ b;
         default: r = {WIDTH{1'b0}};
      endcase
      return {ovf, r};
   endfunction

   logic             ptr_r;
   logic             gnt0_s;
   logic             gnt1_s;
   logic             xfer_s;
   logic [1:0]       op_s;
   logic [WIDTH-1:0] a_s;
   logic [WIDTH-1:0] b_s;
   logic [WIDTH:0]   alu_s;

   logic             rsp_valid_r;
   logic             rsp_id_r;
   logic [WIDTH-1:0] rsp_result_r;
   logic             rsp_overflow_r;

   // Grant and operand mux; with no grant the ALU sees requester 0's operands.
   always_comb begin
      gnt0_s = req0_valid & (~req1_valid | ~ptr_r);
      gnt1_s = req1_valid & (~req0_valid | ptr_r);
      xfer_s = gnt0_s | gnt1_s;
      if (gnt1_s) begin
         op_s = req1_op;
         a_s  = req1_a;
         b_s  = req1_b;
      end else begin
         op_s = req0_op;
         a_s  = req0_a;
         b_s  = req0_b;
      end
      alu_s = alu_f(op_s, a_s, b_s);
   end

   assign req0_ready = gnt0_s;
   assign req1_ready = gnt1_s;

   // Priority pointer and response registers; reset discards any same-cycle transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r          <= 1'b0;
         rsp_valid_r    <= 1'b0;
         rsp_id_r       <= 1'b0;
         rsp_result_r   <= {WIDTH{1'b0}};
         rsp_overflow_r <= 1'b0;
      end else begin
         rsp_valid_r <= xfer_s;
         if (xfer_s) begin
            ptr_r          <= gnt0_s;
            rsp_id_r       <= gnt1_s;
            rsp_result_r   <= alu_s[WIDTH-1:0];
            rsp_overflow_r <= alu_s[WIDTH];
         end
      end
   end

   assign rsp_valid    = rsp_valid_r;
   assign rsp_id       = rsp_id_r;
   assign rsp_result   = rsp_result_r;
   assign rsp_overflow = rsp_overflow_r;

`ifdef ALU_ARB_CC_EN
   logic cc_zf_r;
   logic cc_sf_r;
   logic cc_of_r;

   // Condition codes follow only requester 0 transfers that ask for it.
   always_ff @(posedge clk) begin
      if (rst) begin
         cc_zf_r <= 1'b1;
         cc_sf_r <= 1'b0;
         cc_of_r <= 1'b0;
      end else if (gnt0_s && req0_set_cc) begin
         cc_zf_r <= (alu_s[WIDTH-1:0] == {WIDTH{1'b0}});
         cc_sf_r <= alu_s[WIDTH-1];
         cc_of_r <= alu_s[WIDTH];
      end
   end

   assign cc_zf = cc_zf_r;
   assign cc_sf = cc_sf_r;
   assign cc_of = cc_of_r;
`else
   logic unused_set_cc_s;
   assign unused_set_cc_s = req0_set_cc;
   assign cc_zf = 1'b0;
   assign cc_sf = 1'b0;
   assign cc_of = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter; CC expectations collapse to 0 when
// ALU_ARB_CC_EN is not defined.
module tb_alu_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_set_cc;
   logic [1:0]  req0_op;
   logic [63:0] req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [1:0]  req1_op;
   logic [63:0] req1_a, req1_b;
   logic        rsp_valid, rsp_id, rsp_overflow;
   logic [63:0] rsp_result;
   logic        cc_zf, cc_sf, cc_of;

`ifdef ALU_ARB_CC_EN
   localparam bit CC_ON = 1'b1;
`else
   localparam bit CC_ON = 1'b0;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   alu_arbiter #(.WIDTH(64)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b), .req0_set_cc(req0_set_cc),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_overflow(rsp_overflow), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v0;
      logic [1:0]  op0;
      logic [63:0] a0, b0;
      logic        scc;
      logic        v1;
      logic [1:0]  op1;
      logic [63:0] a1, b1;
      logic        e_r0, e_r1, e_v, e_id, e_ovf;
      logic [63:0] e_res;
      logic        e_zf, e_sf, e_of;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mkv(logic v0, logic [1:0] op0, logic [63:0] a0, logic [63:0] b0,
                                logic scc, logic v1, logic [1:0] op1, logic [63:0] a1,
                                logic [63:0] b1, logic e_r0, logic e_r1, logic e_v,
                                logic e_id, logic [63:0] e_res, logic e_ovf,
                                logic e_zf, logic e_sf, logic e_of);
      vec_t t;
      t.v0 = v0; t.op0 = op0; t.a0 = a0; t.b0 = b0; t.scc = scc;
      t.v1 = v1; t.op1 = op1; t.a1 = a1; t.b1 = b1;
      t.e_r0 = e_r0; t.e_r1 = e_r1; t.e_v = e_v; t.e_id = e_id;
      t.e_res = e_res; t.e_ovf = e_ovf;
      t.e_zf = e_zf; t.e_sf = e_sf; t.e_of = e_of;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_cc(input string tag, input logic zf, input logic sf, input logic of_);
      chk({tag, ".cc_zf"}, {63'd0, cc_zf}, {63'd0, zf & CC_ON});
      chk({tag, ".cc_sf"}, {63'd0, cc_sf}, {63'd0, sf & CC_ON});
      chk({tag, ".cc_of"}, {63'd0, cc_of}, {63'd0, of_ & CC_ON});
   endtask

   initial begin
      // ptr before each row noted at right
      vecs[0]  = mkv(1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1, 1, 2'd2, 64'hFF, 64'h0F,
                     1, 0, 1, 0, 64'h8000_0000_0000_0000, 1, 0, 1, 1);          // ptr 0
      vecs[1]  = mkv(1, 2'd1, 64'h1234, 64'h1234, 1, 0, 2'd0, 64'd0, 64'd0,
                     1, 0, 1, 0, 64'd0, 0, 1, 0, 0);                             // ptr 1
      vecs[2]  = mkv(0, 2'd0, 64'd0, 64'd0, 0, 1, 2'd3, 64'd5, 64'd3,
                     0, 1, 1, 1, 64'd6, 0, 1, 0, 0);                             // ptr 1
      vecs[3]  = mkv(0, 2'd0, 64'd0, 64'd0, 0, 0, 2'd0, 64'd0, 64'd0,
                     0, 0, 0, 1, 64'd6, 0, 1, 0, 0);                             // ptr 0
      vecs[4]  = mkv(1, 2'd1, 64'd0, 64'd1, 0, 1, 2'd0, 64'd10, 64'd20,
                     1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 0);           // ptr 0
      vecs[5]  = mkv(1, 2'd1, 64'd0, 64'd1, 0, 1, 2'd0, 64'd10, 64'd20,
                     0, 1, 1, 1, 64'd30, 0, 1, 0, 0);                            // ptr 1
      vecs[6]  = mkv(1, 2'd2, 64'hF0F0, 64'hFF00, 0, 1, 2'd1,
                     64'h8000_0000_0000_0000, 64'd1,
                     1, 0, 1, 0, 64'hF000, 0, 1, 0, 0);                          // ptr 0
      vecs[7]  = mkv(1, 2'd2, 64'hF0F0, 64'hFF00, 0, 1, 2'd1,
                     64'h8000_0000_0000_0000, 64'd1,
                     0, 1, 1, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0, 0);           // ptr 1
      for (int i = 8; i < 11; i++)
         vecs[i] = mkv(0, 2'd0, 64'd0, 64'd0, 0, 1, 2'd2, 64'hFF, 64'h0F,
                       0, 1, 1, 1, 64'h0F, 0, 1, 0, 0);                          // ptr 0
      vecs[11] = mkv(1, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0, 2'd0, 64'd0, 64'd0,
                     1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 0);           // ptr 0
      vecs[12] = mkv(1, 2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1,
                     0, 2'd0, 64'd0, 64'd0,
                     1, 0, 1, 0, 64'd0, 1, 1, 0, 1);                             // ptr 1

      // Reset held two cycles with both requesters valid.
      rst = 1'b1;
      req0_valid = 1'b1; req0_op = 2'd0; req0_a = 64'd1; req0_b = 64'd2; req0_set_cc = 1'b1;
      req1_valid = 1'b1; req1_op = 2'd0; req1_a = 64'd3; req1_b = 64'd4;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("reset.rsp_valid", {63'd0, rsp_valid}, 64'd0);
      end
      rst = 1'b0;
      #1;
      chk("reset.rsp_result", rsp_result, 64'd0);
      chk("reset.rsp_id", {63'd0, rsp_id}, 64'd0);
      chk("reset.rsp_overflow", {63'd0, rsp_overflow}, 64'd0);
      chk_cc("reset", 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 13; i++) begin
         req0_valid = vecs[i].v0; req0_op = vecs[i].op0;
         req0_a = vecs[i].a0; req0_b = vecs[i].b0; req0_set_cc = vecs[i].scc;
         req1_valid = vecs[i].v1; req1_op = vecs[i].op1;
         req1_a = vecs[i].a1; req1_b = vecs[i].b1;
         #1;
         chk($sformatf("v%0d.req0_ready", i), {63'd0, req0_ready}, {63'd0, vecs[i].e_r0});
         chk($sformatf("v%0d.req1_ready", i), {63'd0, req1_ready}, {63'd0, vecs[i].e_r1});
         @(posedge clk); #1;
         chk($sformatf("v%0d.rsp_valid", i), {63'd0, rsp_valid}, {63'd0, vecs[i].e_v});
         chk($sformatf("v%0d.rsp_id", i), {63'd0, rsp_id}, {63'd0, vecs[i].e_id});
         chk($sformatf("v%0d.rsp_result", i), rsp_result, vecs[i].e_res);
         chk($sformatf("v%0d.rsp_overflow", i), {63'd0, rsp_overflow}, {63'd0, vecs[i].e_ovf});
         chk_cc($sformatf("v%0d", i), vecs[i].e_zf, vecs[i].e_sf, vecs[i].e_of);
      end

      // Mid-operation reset: ptr is 1 here, so requester 1 is granted combinationally.
      rst = 1'b1;
      req0_valid = 1'b1; req0_op = 2'd0; req0_a = 64'h7FFF_FFFF_FFFF_FFFF; req0_b = 64'd1;
      req0_set_cc = 1'b1;
      req1_valid = 1'b1; req1_op = 2'd3; req1_a = 64'd5; req1_b = 64'd3;
      #1;
      chk("midrst.req1_ready", {63'd0, req1_ready}, 64'd1);
      chk("midrst.req0_ready", {63'd0, req0_ready}, 64'd0);
      @(posedge clk); #1;
      chk("midrst.rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("midrst.rsp_result", rsp_result, 64'd0);
      chk_cc("midrst", 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      chk("midrst.ptr_req0_ready", {63'd0, req0_ready}, 64'd1);
      chk("midrst.ptr_req1_ready", {63'd0, req1_ready}, 64'd0);
      @(posedge clk); #1;
      chk("post.rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("post.rsp_id", {63'd0, rsp_id}, 64'd0);
      chk("post.rsp_result", rsp_result, 64'h8000_0000_0000_0000);
      chk_cc("post", 1'b0, 1'b1, 1'b1);
      // Second cycle of contention goes to requester 1.
      #1;
      chk("post.req1_ready", {63'd0, req1_ready}, 64'd1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(posedge clk); #1;
      chk("post2.rsp_valid", {63'd0, rsp_valid}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
